// File: rtl/cmem_pkg.sv
// Shared constants and types for the cmem coefficient memory and its loader.
package cmem_pkg;

  localparam int CMEM_DW   = 16;
  localparam int CMEM_AW   = 6;
  localparam int CMEM_NBLK = 8;
  localparam int CMEM_N    = CMEM_NBLK * (2 ** CMEM_AW);

  // Active-low strobe levels for WEN/CEN
  localparam logic CMEM_ON  = 1'b0;
  localparam logic CMEM_OFF = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } cmem_ld_state_t;

endpackage

// File: rtl/cmem_loader.sv
// Write-side sequencer for cmem: turns a valid/ready coefficient stream into
// one registered cmem write per accepted beat, bank-major / address-minor.
module cmem_loader
  import cmem_pkg::*;
#(
  parameter int DW   = CMEM_DW,
  parameter int AW   = CMEM_AW,
  parameter int NBLK = CMEM_NBLK,
  parameter int CW   = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     s_valid,
  input  logic [DW-1:0]            s_data,
  output logic                     s_ready,
  output logic [DW-1:0]            D,
  output logic                     WEN,
  output logic                     CEN,
  output logic                     busy,
  output logic                     load_done,
  output logic [$clog2(NBLK)-1:0]  wr_blk,
  output logic [AW-1:0]            wr_addr
);

  localparam int BW = $clog2(NBLK);
  localparam logic [CW-1:0] N_WORDS = CW'(NBLK * (2 ** AW));
  localparam logic [CW-1:0] LAST    = CW'(NBLK * (2 ** AW) - 1);

  cmem_ld_state_t  state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   d_q, d_d;
  logic            wen_q, wen_d;
  logic            cen_q, cen_d;
  logic            done_q, done_d;
  logic [BW-1:0]   blk_q, blk_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            accept;

  // Ready depends only on state and count, never on s_valid
  always_comb begin
    s_ready = (state_q == LOAD) && (cnt_q < N_WORDS);
    // abort suppresses the beat offered in the same cycle
    accept  = s_valid && s_ready && !abort;
  end

  // Next-state, counter and write-port logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    wen_d   = CMEM_OFF;
    cen_d   = CMEM_OFF;
    done_d  = done_q;
    blk_d   = blk_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_d = LOAD;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          d_d             = s_data;
          wen_d           = CMEM_ON;
          cen_d           = CMEM_ON;
          {blk_d, addr_d} = cnt_q[CW-2:0];
          cnt_d           = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered cmem write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      d_q     <= '0;
      wen_q   <= CMEM_OFF;
      cen_q   <= CMEM_OFF;
      done_q  <= 1'b0;
      blk_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      wen_q   <= wen_d;
      cen_q   <= cen_d;
      done_q  <= done_d;
      blk_q   <= blk_d;
      addr_q  <= addr_d;
    end
  end

  assign D         = d_q;
  assign WEN       = wen_q;
  assign CEN       = cen_q;
  assign busy      = (state_q == LOAD);
  assign load_done = done_q;
  assign wr_blk    = blk_q;
  assign wr_addr   = addr_q;

endmodule

// File: tb/tb_cmem_loader.sv
// Directed bench for cmem_loader with a reference model and write scoreboard.
module tb_cmem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic [15:0] D;
  logic        WEN;
  logic        CEN;
  logic        busy;
  logic        load_done;
  logic [2:0]  wr_blk;
  logic [5:0]  wr_addr;

  cmem_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .D         (D),
    .WEN       (WEN),
    .CEN       (CEN),
    .busy      (busy),
    .load_done (load_done),
    .wr_blk    (wr_blk),
    .wr_addr   (wr_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: 0 idle, 1 load, 2 done
  int          m_state;
  int          m_cnt;
  logic        m_done;
  logic [15:0] m_d;
  logic [8:0]  m_ba;
  logic [24:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    m_done  = 1'b0;
    m_d     = '0;
    m_ba    = '0;
    sb.delete();
  endtask

  task automatic tick();
    logic        rdy;
    logic        acc;
    logic [24:0] e;
    logic [9:0]  c10;
    rdy = (m_state == 1) && (m_cnt < 512);
    chk("s_ready", 32'(s_ready), 32'(rdy));
    acc = s_valid && rdy && !abort;
    c10 = 10'(m_cnt);
    if (acc) sb.push_back({s_data, c10[8:0]});
    case (m_state)
      0, 2: if (start && !abort) begin m_state = 1; m_cnt = 0; m_done = 1'b0; end
      1: begin
        if (abort) begin
          m_state = 0; m_cnt = 0;
        end else if (acc) begin
          m_cnt++;
          if (m_cnt == 512) begin m_state = 2; m_done = 1'b1; end
        end
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
    if (WEN === 1'b0) begin
      chk("wr_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e    = sb.pop_front();
        m_d  = e[24:9];
        m_ba = e[8:0];
      end
    end
    chk("WEN", 32'(WEN), 32'(!acc));
    chk("CEN", 32'(CEN), 32'(!acc));
    chk("D", 32'(D), 32'(m_d));
    chk("blk_addr", 32'({wr_blk, wr_addr}), 32'(m_ba));
    chk("busy", 32'(busy), 32'(m_state == 1));
    chk("load_done", 32'(load_done), 32'(m_done));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_D"}, 32'(D), 32'd0);
    chk({tag, "_WEN"}, 32'(WEN), 32'd1);
    chk({tag, "_CEN"}, 32'(CEN), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_blk"}, 32'(wr_blk), 32'd0);
    chk({tag, "_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_ready"}, 32'(s_ready), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0;
    model_reset();
    #12;
    check_reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Full gapless load, data = index
    pulse_start();
    for (int i = 0; i < 512; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(i);
      tick();
      if (i == 63)  chk("wrap_63",  32'({wr_blk, wr_addr}), {26'd0, 3'd0, 6'd63});
      if (i == 64)  chk("wrap_64",  32'({wr_blk, wr_addr}), {26'd0, 3'd1, 6'd0});
      if (i == 511) chk("last_511", 32'({wr_blk, wr_addr}), {26'd0, 3'd7, 6'd63});
    end
    chk("full_done", 32'(load_done), 32'd1);
    // s_valid in DONE is ignored
    for (int i = 0; i < 3; i++) tick();
    s_valid = 1'b0;
    tick();

    // Reload from DONE with alternating valid
    pulse_start();
    for (int i = 0; i < 1023; i++) begin
      s_valid = (i % 2 == 0);
      s_data  = 16'($urandom);
      tick();
    end
    s_valid = 1'b0;
    chk("alt_done", 32'(load_done), 32'd1);
    tick();

    // Abort at cnt=200 while a beat is offered
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      s_valid = 1'b1; s_data = 16'(i + 16'h1000); tick();
    end
    abort = 1'b1; s_data = 16'hdead;
    tick();
    abort = 1'b0; s_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    tick();
    pulse_start();
    s_valid = 1'b1; s_data = 16'h00aa;
    tick();
    chk("restart_addr", 32'({wr_blk, wr_addr}), 32'd0);

    // start during LOAD is ignored
    start = 1'b1; s_data = 16'h00bb;
    tick();
    start = 1'b0;
    for (int i = 0; i < 298; i++) begin
      s_data = 16'($urandom); tick();
    end
    // Async reset mid-load at cnt=300
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_values("async");
    model_reset();
    #1 rst_n = 1'b1;
    tick();

    // s_valid in IDLE, then start+abort together in IDLE
    s_valid = 1'b1; s_data = 16'h5555;
    tick(); tick();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0; s_valid = 1'b0;
    chk("sa_idle_busy", 32'(busy), 32'd0);
    tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
